cpu_run_controller: RTL
=======================

# cpu_run_controller

Run/load sequencer for the single-cycle 16-bit CPU.
- Streams a program into instruction memory over a valid/ready word interface, holding the CPU in reset during the load.
- Then gates CPU execution with run, single-step and halt commands, and stops automatically when the program counter passes the loaded program length.
- Sits between the host/testbench and the CPU top level; drives the instruction-memory write port, the CPU reset and a per-cycle execute enable.

## Interface
- DATA_W, 16, instruction word width
- ADDR_W, 8, instruction address / program counter width
- DEPTH, 16, instruction memory words; legal load lengths 1..DEPTH (DEPTH ≤ 2^ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- load_start  in  1  one-cycle pulse: begin program load
- load_len  in  ADDR_W  word count, sampled with load_start
- in_valid  in  1  in_data holds a word
- in_ready  out  1  controller accepts a word this cycle
- in_data  in  DATA_W  program word
- run_cmd  in  1  pulse: free-run
- step_cmd  in  1  pulse: execute one instruction
- halt_cmd  in  1  pulse: stop execution
- pc  in  ADDR_W  current CPU program counter
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  DATA_W  write data
- cpu_en  out  1  CPU executes (PC advances, regs/mem write) this cycle
- cpu_rst_n  out  1  active-low CPU reset
- state  out  3  FSM state encoding
- done  out  1  one-cycle pulse: program end reached
- err  out  1  one-cycle pulse: illegal load_len

## Operation
- States / encodings: IDLE=0, LOAD=1, CLR=2, HALT=3, RUN=4, STEP=5.
- IDLE (after reset):
  - cpu_rst_n=0.
  - load_start with legal len → LOAD; prog_len←len; word count cnt←0.
  - run_cmd/step_cmd/halt_cmd are ignored.
- load_start with len=0 or len>DEPTH: err pulse next cycle; state and prog_len unchanged. Applies in IDLE or HALT.
- LOAD:
  - in_ready=1 and cpu_rst_n=0.
  - Each in_valid&in_ready writes in_data to address cnt, then cnt++.
  - The handshake that accepts word len-1 → CLR.
  - Commands and load_start are ignored.
- CLR: in_ready=0, cpu_rst_n=0 for exactly one cycle, which resets the PC to 0; → HALT.
- HALT: cpu_rst_n=1, cpu_en=0.
  - Command priority: halt_cmd > step_cmd > run_cmd > load_start.
  - run_cmd → RUN.
  - step_cmd → STEP.
  - load_start (legal) → LOAD; new program overwrites from address 0.
- RUN:
  - cpu_en = (pc < prog_len) & ~halt_cmd (combinational).
  - halt_cmd → HALT, no done.
  - pc ≥ prog_len → HALT with done pulse.
  - step_cmd, run_cmd and load_start are ignored.
- STEP:
  - If pc < prog_len: cpu_en=1 for exactly this one cycle, then → HALT.
  - If pc ≥ prog_len: cpu_en=0, done pulse, → HALT.
  - halt_cmd in the STEP cycle suppresses cpu_en.
- The pc/prog_len comparison is unsigned and ADDR_W bits wide; no wrap beyond prog_len is possible.
- Reset low in any state, including mid-load or mid-run:
  - Immediate return to IDLE with prog_len=0.
  - Partially loaded words stay in memory but are not runnable until a new full load completes.

## Timing
- Reset values: state=0, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_en=0, cpu_rst_n=0, done=0, err=0.
- in_ready, cpu_rst_n, state, done and err are registered.
- cpu_en is combinational from the registered state, pc, prog_len and halt_cmd.
- Write-port latency is one cycle: a handshake at edge t drives imem_we=1 with imem_addr=cnt and imem_wdata=in_data during cycle t+1.
- in_ready drops in the cycle after the last handshake (CLR). A valid word presented then is not accepted.
- Load of N words takes N handshake cycles, plus 1 CLR cycle, before HALT. Minimum load_start→HALT is N+2 cycles.
- A command pulse sampled at edge t takes effect on state at t+1. The first RUN cycle therefore executes pc=0.
- done and err are high for exactly one cycle. They are asserted in the cycle after the state transition that caused them.

## Test plan
- Reset, then load len=14 with in_valid held high → 14 imem_we pulses at addresses 0..13 with the matching data; 1 CLR cycle with cpu_rst_n=0; state=3; in_ready=0 afterwards.
- Load len=4 with in_valid toggling 1/0 → writes occur only on handshake cycles, addresses 0..3 are contiguous, total LOAD duration 8 cycles.
- After a len=5 load, run_cmd with the PC model incrementing on cpu_en → cpu_en high for exactly 5 cycles (pc 0..4); done pulse once; state=3.
- After a len=5 load: step_cmd ×3 → 3 single cpu_en cycles with pc=3 afterwards. Then run_cmd followed by halt_cmd at pc=4 → cpu_en low in the halt_cmd cycle; no done.
- load_len=0, then load_len=17 (DEPTH=16) → one err pulse each, state unchanged. load_start during RUN → ignored.
- Reset asserted after 3 of 8 words loaded → all outputs return to reset values immediately. A subsequent run_cmd in IDLE → no cpu_en.

Source files
------------

// File: rtl/cpu_run_controller.sv
// Run/load sequencer for the single-cycle 16-bit CPU: streams a program into
// instruction memory, then gates CPU execution with run/step/halt commands.
module cpu_run_controller #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              run_cmd,
    input  logic              step_cmd,
    input  logic              halt_cmd,
    input  logic [ADDR_W-1:0] pc,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_en,
    output logic              cpu_rst_n,
    output logic [2:0]        state,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CLR  = 3'd2,
        S_HALT = 3'd3,
        S_RUN  = 3'd4,
        S_STEP = 3'd5
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                rst_n_q, rst_n_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                len_ok;
    logic                hs;
    logic                in_prog;

    assign len_ok  = (load_len != '0) && ({1'b0, load_len} <= DEPTH_W);
    assign hs      = in_ready_q & in_valid;
    assign in_prog = pc < len_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cpu_en  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    if (len_ok) begin
                        state_d = S_LOAD;
                        len_d   = load_len;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (hs) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = in_data;
                    cnt_d   = cnt_q + ONE;
                    if (cnt_q == len_q - ONE) state_d = S_CLR;
                end
            end
            S_CLR: state_d = S_HALT;
            S_HALT: begin
                // halt > step > run > load_start
                if (halt_cmd) begin
                    state_d = S_HALT;
                end else if (step_cmd) begin
                    state_d = S_STEP;
                end else if (run_cmd) begin
                    state_d = S_RUN;
                end else if (load_start) begin
                    if (len_ok) begin
                        state_d = S_LOAD;
                        len_d   = load_len;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cpu_en = in_prog & ~halt_cmd;
                if (halt_cmd) begin
                    state_d = S_HALT;
                end else if (!in_prog) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end
            end
            S_STEP: begin
                cpu_en  = in_prog & ~halt_cmd;
                done_d  = ~in_prog;
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LOAD);
        rst_n_d    = (state_d == S_HALT) || (state_d == S_RUN) || (state_d == S_STEP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            rst_n_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            rst_n_q    <= rst_n_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign cpu_rst_n  = rst_n_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign state      = state_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
